shift_queue: RTL and testbench

//   Parametrised queue of shift requests. Each request holds a data word, an op code and a shift amount.

---
 rtl/shift_queue.sv | 140 ++++++++++++++
 tb/tb_shift_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_queue.sv
// Queue of shift requests feeding a registered barrel-shift output stage.
// Results carry registered AND/OR/XOR reduction flags of the shifted word.
module shift_queue #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 32,
    parameter int SHW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [1:0]               in_op,
    input  logic [SHW-1:0]           in_amt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_and,
    output logic                     out_or,
    output logic                     out_xor,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int unsigned WU   = WIDTH;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [1:0]       op_q   [DEPTH];
    logic [SHW-1:0]   amt_q  [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             and_q, and_d;
    logic             or_q, or_d;
    logic             xor_q, xor_d;
    logic             overflow_q, overflow_d;
    logic             push, load;
    logic [WIDTH-1:0] shifted;

    function automatic logic [WIDTH-1:0] do_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic [SHW-1:0]   amt
    );
        int unsigned      a;
        int unsigned      r;
        logic [WIDTH-1:0] res;
        a = 32'(amt);
        r = a % WU;
        case (op)
            OP_SLL:  res = (a >= WU) ? '0 : (d << a);
            OP_SRL:  res = (a >= WU) ? '0 : (d >> a);
            OP_SRA:  res = (a >= WU) ? {WIDTH{d[WIDTH-1]}} : $unsigned($signed(d) >>> a);
            OP_ROL:  res = (r == 0) ? d : ((d << r) | (d >> (WU - r)));
            default: res = d;
        endcase
        return res;
    endfunction

    assign in_ready = !reset && !flush && (count_q < FULL);

    always_comb begin
        push        = in_valid && in_ready;
        load        = (count_q != '0) && (!out_valid_q || out_ready);
        shifted     = do_shift(data_q[rd_ptr_q], op_q[rd_ptr_q], amt_q[rd_ptr_q]);
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (push && !load) count_d = count_q + 1'b1;
        if (load && !push) count_d = count_q - 1'b1;
        out_valid_d = out_valid_q;
        if (load)           out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        out_data_d  = load ? shifted : out_data_q;
        overflow_d  = overflow_q || (in_valid && (count_q == FULL));
        // Flush overrides the load; the output word and its flags keep their last value.
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end
        and_d = &out_data_d;
        or_d  = |out_data_d;
        xor_d = ^out_data_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= in_data;
            op_q[wr_ptr_q]   <= in_op;
            amt_q[wr_ptr_q]  <= in_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            and_q       <= 1'b0;
            or_q        <= 1'b0;
            xor_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            and_q       <= and_d;
            or_q        <= or_d;
            xor_q       <= xor_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_and   = and_q;
    assign out_or    = or_q;
    assign out_xor   = xor_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_shift_queue.sv
// Scoreboard bench for shift_queue: accepted requests push a bit-level model result,
// the output monitor pops and compares data and reduction flags on each handshake.
module tb_shift_queue;

    localparam int WIDTH = 9;
    localparam int DEPTH = 32;
    localparam int SHW   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [1:0]       in_op;
    logic [SHW-1:0]   in_amt;
    logic             out_and, out_or, out_xor, overflow;
    logic [CW-1:0]    count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [WIDTH-1:0] sb [$];

    shift_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SHW(SHW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_and(out_and), .out_or(out_or), .out_xor(out_xor),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Bitwise reference: each result bit is picked from its source position.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [1:0] op,
                                                 input int a);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            case (op)
                2'd0: r[i] = (i - a >= 0) ? d[i-a] : 1'b0;
                2'd1: r[i] = (i + a < WIDTH) ? d[i+a] : 1'b0;
                2'd2: r[i] = (i + a < WIDTH) ? d[i+a] : d[WIDTH-1];
                default: r[i] = d[(i - (a % WIDTH) + WIDTH) % WIDTH];
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_underflow", 32'(out_data), 32'hDEAD);
            else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e));
                check("out_and", 32'(out_and), 32'(&e));
                check("out_or", 32'(out_or), 32'(|e));
                check("out_xor", 32'(out_xor), 32'(^e));
            end
        end
    end

    task automatic push(input logic [WIDTH-1:0] d, input logic [1:0] op, input logic [SHW-1:0] a);
        logic acc;
        in_valid = 1'b1; in_data = d; in_op = op; in_amt = a;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (acc) sb.push_back(model(d, op, int'(a)));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (sb.size() == 0) break;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk); #2;
        check("drain_out_valid", 32'(out_valid), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("in_ready_in_reset", 32'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_op = '0; in_amt = '0;
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_flags", {29'b0, out_and, out_or, out_xor}, 0);
        check("rst_out_data", 32'(out_data), 0);
        @(posedge clk); #1;

        // SLL and first-result latency
        out_ready = 1'b1;
        push(9'h0A5, 2'd0, 4'd3);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 0);
        check("lat_count", 32'(count), 1);
        @(negedge clk);
        check("lat_out_valid_next", 32'(out_valid), 1);
        check("sll_value", 32'(out_data), 32'h128);
        drain();

        // SRA / SRL / ROL boundaries
        push(9'h100, 2'd2, 4'd2);
        push(9'h100, 2'd2, 4'd12);
        push(9'h100, 2'd1, 4'd12);
        push(9'h181, 2'd3, 4'd10);
        push(9'h181, 2'd3, 4'd9);
        drain();

        // sustained throughput: count stays at one with out_ready high
        for (int i = 0; i < 10; i++) push(9'(i * 37), 2'(i), 4'(i));
        @(negedge clk);
        check("stream_count", 32'(count), 1);
        check("stream_out_valid", 32'(out_valid), 1);
        drain();

        // fill and overflow with stalled consumer, then drain across the wrap
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) push(9'($urandom), 2'($urandom), 4'($urandom));
        @(negedge clk);
        check("full_count", 32'(count), DEPTH);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_overflow", 32'(overflow), 1);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_sb_size", sb.size(), DEPTH + 1);
        @(posedge clk); #1;
        drain();

        // random traffic with a bursty consumer
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) push(9'($urandom), 2'($urandom), 4'($urandom));
            else begin @(posedge clk); #1; end
        end
        drain();

        // flush with 5 entries queued and a push attempted on the flush edge
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(9'(i + 1), 2'd0, 4'd0);
        @(negedge clk);
        check("pre_flush_count", 32'(count), 5);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_data = 9'h155; in_op = 2'd0; in_amt = 4'd0;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_count", 32'(count), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_overflow", 32'(overflow), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(9'h00F, 2'd0, 4'd1);
        drain();

        // reset mid-stream discards everything and clears overflow
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(9'h0F0, 2'd3, 4'(i));
        do_reset();
        @(negedge clk);
        check("midrst_count", 32'(count), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_overflow", 32'(overflow), 0);
        check("midrst_out_data", 32'(out_data), 0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
